axis_pkt_fifo_dw: RTL
=====================

Name: axis_pkt_fifo_dw

Overview:
- Single-clock AXI-Stream FIFO with integrated N:1 upsizing: S_DATA_WIDTH slave beats are packed into M_DATA_WIDTH words before storage. Per-word tkeep is generated correctly on short final beats.
- Carries tid/tuser, exports a programmable-full flow-control flag and occupancy, and has an optional packet (store-and-forward) mode.
- Sits between a narrow read-data producer and the wide host-side stream sink. It is the next-generation read data FIFO for same-clock datapaths.

Parameters:
- S_DATA_WIDTH, 32, slave data width; multiple of 8.
- M_DATA_WIDTH, 128, master data width; RATIO = M_DATA_WIDTH/S_DATA_WIDTH, power of 2, 1..16.
- DEPTH, 64, FIFO depth in M-width words; power of 2, >= 4.
- PROG_FULL_THRESH, 48, occupancy (words) at or above which prog_full asserts; 1..DEPTH-1.
- PACKET_MODE, 0, 1 = hold a packet until its tlast word is stored.
- ID_WIDTH, 16, tid width.
- USER_WIDTH, 4, tuser width.

Ports:
- aclk, input, 1, single clock.
- aresetn, input, 1, asynchronous active-low reset.
- s_axis_tvalid, input, 1, slave valid.
- s_axis_tready, output, 1, slave ready.
- s_axis_tdata, input, S_DATA_WIDTH, slave data.
- s_axis_tlast, input, 1, end of packet.
- s_axis_tid, input, ID_WIDTH, stream id.
- s_axis_tuser, input, USER_WIDTH, sideband.
- m_axis_tvalid, output, 1, master valid.
- m_axis_tready, input, 1, master ready.
- m_axis_tdata, output, M_DATA_WIDTH, packed data.
- m_axis_tkeep, output, M_DATA_WIDTH/8, byte enables.
- m_axis_tlast, output, 1, end of packet.
- m_axis_tid, output, ID_WIDTH.
- m_axis_tuser, output, USER_WIDTH.
- s_fifo_ready, output, 1, equals ~prog_full; upstream throttle.
- fifo_count, output, log2(DEPTH)+1, stored words.

Behaviour:
- Reset (aresetn low, asynchronous):
  - Clears lane index, pack register, read/write pointers, count and packet count.
  - Outputs: s_axis_tready=0, m_axis_tvalid=0, fifo_count=0, s_fifo_ready=1.
  - s_axis_tready rises on the first aclk edge after reset release.
  - A packet in flight when reset asserts is discarded entirely.
- Slave side:
  - s_axis_tready = ~full (registered full flag). Beat accepted on tvalid&tready.
  - Beats fill lanes low to high: beat k of a word goes to bits [k*S +: S].
- Word completion:
  - A word completes on the accepted beat where lane index = RATIO-1 or s_axis_tlast=1.
  - The completing beat is merged with the pack register and written to the FIFO in the same cycle. The lane index then returns to 0.
  - Stored tkeep has all ones for filled lanes and zero for unfilled lanes. Unfilled data lanes are 0.
  - Stored tid/tuser come from the completing beat.
  - Stored tlast equals s_axis_tlast of the completing beat.
- RATIO=1: every beat is a word.
- Latency: a word written at edge N is presented with m_axis_tvalid=1 after edge N (visible in cycle N+1).
- Master side:
  - First-word-fall-through from the memory.
  - Word popped on m_axis_tvalid&m_axis_tready.
  - All m_axis_t* payload outputs are forced to 0 while m_axis_tvalid=0.
  - Valid, once high, stays high until the handshake.
- Count and flags:
  - fifo_count +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
  - full = (count==DEPTH); empty = (count==0).
  - prog_full = (count >= PROG_FULL_THRESH), registered.
  - Pointers wrap modulo DEPTH.
- Full and empty: write is impossible when full (tready=0). Pop is impossible when empty.
- PACKET_MODE=1:
  - pkt_cnt +1 when a tlast word is written, -1 when a tlast word is popped.
  - m_axis_tvalid = ~empty & (pkt_cnt>0 | full). The full override prevents deadlock on packets longer than DEPTH.
  - A tlast write and a tlast pop in the same cycle leave pkt_cnt unchanged.
- PACKET_MODE=0: m_axis_tvalid = ~empty.

Decomposition:
- Shared package axis_fifo_pkg:
  - clog2 function.
  - RATIO, KEEP_S (S/8) and ADDR_WIDTH derivation constants.
  - Beat/word record layout offsets: data, keep, last, id, user.
- Sub-module sync_fifo_mem: DEPTH x (M + M/8 + 1 + ID + USER) memory with registered write and asynchronous read. Pointer, count and flag logic stay in the top module.

Test Plan:
- Four 32-bit beats 0x11111111..0x44444444, tlast on beat 4, tid=0x0005 -> one word 0x44444444_33333333_22222222_11111111, tkeep=0xFFFF, tlast=1, tid=0x0005, valid one cycle after beat 4.
- Six-beat packet 0xA0..0xA5 -> word 1 full with tkeep=0xFFFF; word 2 = 0x...000000A5_000000A4 with tkeep=0x00FF, tlast=1.
- m_axis_tready=0, stream 256 full beats (64 words) -> s_fifo_ready falls after word 48; s_axis_tready=0 at fifo_count=64; first pop re-raises tready next cycle; no word lost or duplicated.
- PACKET_MODE=1, 3-word packet with a 10-cycle gap before its final beat -> m_axis_tvalid stays 0 until the cycle after the tlast word is written.
- PACKET_MODE=1, 80-word packet with DEPTH=64 -> valid asserts at fifo_count=64; the full packet drains intact.
- Assert aresetn low mid-packet after 2 beats -> fifo_count=0, m_axis_tvalid=0 immediately; the next 4-beat packet after reset starts at lane 0.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers and stored-record layout for the upsizing packet FIFO.
// A stored word is packed as {user, id, last, keep, data}, with data at bit 0.
package axis_fifo_pkg;

   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result++;
         rem = rem >> 1;
      end
      return result;
   endfunction

   function automatic int ratio(input int s_width, input int m_width);
      return m_width / s_width;
   endfunction

   function automatic int keep_w(input int data_width);
      return data_width / 8;
   endfunction

   function automatic int addr_width(input int depth);
      return clog2(depth);
   endfunction

   localparam int DATA_OFF = 0;

   function automatic int keep_off(input int m_width);
      return m_width;
   endfunction

   function automatic int last_off(input int m_width);
      return m_width + keep_w(m_width);
   endfunction

   function automatic int id_off(input int m_width);
      return last_off(m_width) + 1;
   endfunction

   function automatic int user_off(input int m_width, input int id_width);
      return id_off(m_width) + id_width;
   endfunction

   function automatic int rec_width(input int m_width, input int id_width, input int user_width);
      return user_off(m_width, id_width) + user_width;
   endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Word storage for the packet FIFO: registered write, asynchronous read.
// Pointer, count and flag logic live in the parent.
module sync_fifo_mem
   import axis_fifo_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int WIDTH      = 149,
   parameter int ADDR_WIDTH = clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_pkt_fifo_dw.sv
// AXI-Stream FIFO that packs RATIO narrow slave beats into one wide word before
// storage, with tid/tuser, programmable-full, occupancy and optional packet mode.
module axis_pkt_fifo_dw
   import axis_fifo_pkg::*;
#(
   parameter int S_DATA_WIDTH     = 32,
   parameter int M_DATA_WIDTH     = 128,
   parameter int DEPTH            = 64,
   parameter int PROG_FULL_THRESH = 48,
   parameter int PACKET_MODE      = 0,
   parameter int ID_WIDTH         = 16,
   parameter int USER_WIDTH       = 4
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                      s_axis_tlast,
   input  logic [ID_WIDTH-1:0]       s_axis_tid,
   input  logic [USER_WIDTH-1:0]     s_axis_tuser,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic [M_DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [M_DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                      m_axis_tlast,
   output logic [ID_WIDTH-1:0]       m_axis_tid,
   output logic [USER_WIDTH-1:0]     m_axis_tuser,
   output logic                      s_fifo_ready,
   output logic [clog2(DEPTH):0]     fifo_count
);

   localparam int unsigned RATIO  = ratio(S_DATA_WIDTH, M_DATA_WIDTH);
   localparam int          KEEP_S = keep_w(S_DATA_WIDTH);
   localparam int          KEEP_M = keep_w(M_DATA_WIDTH);
   localparam int          AW     = addr_width(DEPTH);
   localparam int          LANE_W = (RATIO > 1) ? clog2(RATIO) : 1;
   localparam int          REC_W  = rec_width(M_DATA_WIDTH, ID_WIDTH, USER_WIDTH);
   localparam int          K_OFF  = keep_off(M_DATA_WIDTH);
   localparam int          L_OFF  = last_off(M_DATA_WIDTH);
   localparam int          I_OFF  = id_off(M_DATA_WIDTH);
   localparam int          U_OFF  = user_off(M_DATA_WIDTH, ID_WIDTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW:0] THR_W   = (AW+1)'(PROG_FULL_THRESH);

   logic [LANE_W-1:0]       lane;
   logic [M_DATA_WIDTH-1:0] pack;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [AW:0]             count, count_next, pkt_cnt, pkt_cnt_next;
   logic                    rdy, prog_full;
   logic                    accept, complete, wr_en, rd_en, full, empty, valid;
   logic                    wr_last, rd_last;
   logic [M_DATA_WIDTH-1:0] word_data;
   logic [KEEP_M-1:0]       word_keep;
   logic [REC_W-1:0]        wr_rec, rd_rec;

   assign full     = (count == DEPTH_W);
   assign empty    = (count == '0);
   assign accept   = s_axis_tvalid & rdy;
   assign complete = (lane == LANE_W'(RATIO - 1)) | s_axis_tlast;
   assign wr_en    = accept & complete;
   assign rd_en    = valid & m_axis_tready;
   assign wr_last  = wr_en & s_axis_tlast;
   assign rd_last  = rd_en & rd_rec[L_OFF];

   // Lanes below the current beat come from the pack register, lanes above are zero.
   always_comb begin
      word_data = '0;
      word_keep = '0;
      for (int unsigned j = 0; j < RATIO; j++) begin
         if (j < 32'(lane)) begin
            word_data[j*S_DATA_WIDTH +: S_DATA_WIDTH] = pack[j*S_DATA_WIDTH +: S_DATA_WIDTH];
            word_keep[j*KEEP_S +: KEEP_S]             = '1;
         end else if (j == 32'(lane)) begin
            word_data[j*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
            word_keep[j*KEEP_S +: KEEP_S]             = '1;
         end
      end
   end

   assign wr_rec = {s_axis_tuser, s_axis_tid, s_axis_tlast, word_keep, word_data};

   always_comb begin
      count_next = count;
      unique case ({wr_en, rd_en})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
      pkt_cnt_next = pkt_cnt;
      unique case ({wr_last, rd_last})
         2'b10:   pkt_cnt_next = pkt_cnt + 1'b1;
         2'b01:   pkt_cnt_next = pkt_cnt - 1'b1;
         default: pkt_cnt_next = pkt_cnt;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lane      <= '0;
         pack      <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         pkt_cnt   <= '0;
         rdy       <= 1'b0;
         prog_full <= 1'b0;
      end else begin
         if (accept) begin
            if (complete) begin
               lane <= '0;
               pack <= '0;
            end else begin
               lane <= lane + 1'b1;
               pack[lane*S_DATA_WIDTH +: S_DATA_WIDTH] <= s_axis_tdata;
            end
         end
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count     <= count_next;
         pkt_cnt   <= pkt_cnt_next;
         rdy       <= (count_next != DEPTH_W);
         prog_full <= (count_next >= THR_W);
      end
   end

   sync_fifo_mem #(
      .DEPTH      (DEPTH),
      .WIDTH      (REC_W),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk     (aclk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (wr_rec),
      .rd_addr (rd_ptr),
      .rd_data (rd_rec)
   );

   // Full override in packet mode lets packets longer than DEPTH drain.
   assign valid = ~empty & ((PACKET_MODE == 0) | (pkt_cnt != '0) | full);

   assign s_axis_tready = rdy;
   assign s_fifo_ready  = ~prog_full;
   assign fifo_count    = count;
   assign m_axis_tvalid = valid;
   assign m_axis_tdata  = valid ? rd_rec[DATA_OFF +: M_DATA_WIDTH] : '0;
   assign m_axis_tkeep  = valid ? rd_rec[K_OFF +: KEEP_M] : '0;
   assign m_axis_tlast  = valid & rd_rec[L_OFF];
   assign m_axis_tid    = valid ? rd_rec[I_OFF +: ID_WIDTH] : '0;
   assign m_axis_tuser  = valid ? rd_rec[U_OFF +: USER_WIDTH] : '0;

endmodule
